serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, which sets the operand and difference width in bits (minimum 2).
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have a port rst, input, 1 bit: reset, which is synchronous and active-high.
REQ-004 The block SHALL have a port start, input, 1 bit: request to begin a subtraction, sampled on the rising edge of clk.
REQ-005 The block SHALL have a port a, input, WIDTH bits: the minuend, sampled only when start is accepted.
REQ-006 The block SHALL have a port b, input, WIDTH bits: the subtrahend, sampled only when start is accepted.
REQ-007 The block SHALL have a port bin, input, 1 bit: the borrow-in, sampled only when start is accepted.
REQ-008 The block SHALL have a port busy, output, 1 bit: high while an operation is in progress (SHIFT state).
REQ-009 The block SHALL have a port done, output, 1 bit: a one-cycle pulse marking that d and bout hold a new result.
REQ-010 The block SHALL have a port d, output, WIDTH bits: the registered difference, computed as a - b - bin modulo 2^WIDTH.
REQ-011 The block SHALL have a port bout, output, 1 bit: the registered borrow-out, which is 1 when a < b + bin as unsigned values.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1 at an edge E, the block SHALL load a and b into shift registers, load bin into the borrow flip-flop, clear the bit counter and enter SHIFT.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-015 On each SHIFT edge, the block SHALL process the LSBs a0 and b0 with the borrow flip-flop br as follows:
- difference bit = a0^b0^br;
- next br = (~a0&b0)|(~(a0^b0)&br);
- shift both operand registers right by one;
- shift the difference bit into the MSB of the result shift register;
- increment the counter.
REQ-016 The block SHALL perform exactly WIDTH SHIFT edges (E+1..E+WIDTH); on edge E+WIDTH it SHALL load d from the full result, load bout from the final borrow, and enter DONE.
REQ-017 done SHALL be 1 only in DONE, i.e. for exactly one cycle between edges E+WIDTH and E+WIDTH+1; DONE SHALL always return to IDLE on the next edge.
REQ-018 busy SHALL be 1 only in SHIFT.
REQ-019 start asserted in SHIFT or DONE SHALL be ignored, with no effect on the operation in progress or on the operand registers.
REQ-020 Changes on a, b or bin after the accepting edge SHALL NOT affect the result.
REQ-021 d and bout SHALL hold their last values from DONE through IDLE and SHIFT until the next DONE entry; intermediate shift values SHALL never appear on d.
REQ-022 Back-to-back operation SHALL be possible: start held high continuously SHALL be accepted again in the IDLE cycle following DONE, giving one result every WIDTH+2 cycles.
REQ-023 The counter SHALL be wide enough for WIDTH without wrap; terminal count is WIDTH-1 as observed at the final SHIFT edge.

Reset
REQ-024 When rst=1 at an edge, the block SHALL set state=IDLE, busy=0, done=0, d=0, bout=0, counter=0, br=0 and clear the operand registers.
REQ-025 rst SHALL take priority over start and over all FSM activity.
REQ-026 A reset mid-SHIFT SHALL abort the operation with no done pulse, and d SHALL read 0 afterwards.
REQ-027 The first start after rst deasserts SHALL be accepted at the first edge with rst=0 and start=1.

Verification
REQ-028 The bench SHALL check a nominal subtraction: WIDTH=8, a=0x5A, b=0x3C, bin=0, start at edge E -> busy high for edges E+1..E+8, done high for the single cycle after E+8, d=0x1E, bout=0.
REQ-029 The bench SHALL check an underflow case: a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1.
REQ-030 The bench SHALL check borrow-in handling: a=0x80, b=0x7F, bin=1 -> d=0x00, bout=0; and a=0xFF, b=0xFF, bin=1 -> d=0xFF, bout=1.
REQ-031 The bench SHALL check that start is ignored while busy: start a=0x10, b=0x01; pulse start with a=0x00, b=0xFF at edge E+3 -> result d=0x0F, bout=0, exactly one done pulse, at E+8.
REQ-032 The bench SHALL check reset mid-operation: rst=1 at edge E+4 -> busy=0, done stays 0, d=0x00, bout=0; a new start then completes normally.
REQ-033 The bench SHALL run a self-checking sweep: with start held high continuously, done SHALL pulse every 10 cycles; an exhaustive run at WIDTH=4 over all a, b and bin values SHALL be compared against a - b - bin.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and presents the registered difference and borrow-out with a one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  // Counter holds 0..WIDTH so the increment on the last shift never wraps.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             dbit;
  logic             br_nxt;

  always_comb begin
    dbit   = sa[0] ^ sb[0] ^ br;
    br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            sr    <= '0;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= {dbit, sr[WIDTH-1:1]};
          br  <= br_nxt;
          cnt <= cnt + 1'b1;
          // d is loaded straight from the final shift so partial results never show.
          if (cnt == CW'(WIDTH - 1)) begin
            d     <= {dbit, sr[WIDTH-1:1]};
            bout  <= br_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
